eight_bit_counter_behaviour: RTL and testbench

//   Free-running binary up-counter, default 8 bits wide, behavioural RTL.

---
 rtl/eight_bit_counter_behaviour.sv | 51 +++++
 tb/tb_eight_bit_counter_behaviour.sv | 138 +++++++++++++
 2 files changed

// File: rtl/eight_bit_counter_behaviour.sv
// ---------------------------------------------------------------------------
// eight_bit_counter_behaviour
//   Free-running binary up-counter, wraps modulo 2^WIDTH. Provides a
//   combinational terminal-count flag and a registered one-cycle wrap pulse
//   for cascading and sequencing logic.
//
// Parameters
//   WIDTH        counter width in bits (2..32)
//   RESET_VALUE  value loaded into out while rst is low
//   STEP         increment per clock (1..2^WIDTH-1), modulo 2^WIDTH
//
// Ports
//   Clk   in   clock, all state updates on rising edge
//   rst   in   synchronous reset, active low (0 = reset)
//   out   out  current count, straight from a register
//   tc    out  1 when out + STEP would carry out of WIDTH bits
//   wrap  out  registered pulse, high the cycle after out wrapped
// ---------------------------------------------------------------------------
module eight_bit_counter_behaviour #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      STEP        = 1
) (
    input  logic             Clk,
    input  logic             rst,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    // One extra bit holds the carry; it feeds both tc and the wrap register,
    // so the pulse is simply tc delayed by one edge.
    logic [WIDTH:0] sum;

    assign sum = {1'b0, out} + {1'b0, STEP_W};
    assign tc  = sum[WIDTH];

    // Reset takes priority over both counting and wrap generation.
    always_ff @(posedge Clk) begin
        if (!rst) begin
            out  <= RESET_VALUE;
            wrap <= 1'b0;
        end else begin
            out  <= sum[WIDTH-1:0];
            wrap <= sum[WIDTH];
        end
    end

endmodule

// File: tb/tb_eight_bit_counter_behaviour.sv
module tb_eight_bit_counter_behaviour;

    logic       Clk = 1'b0;
    logic       rst_a, rst_b;
    logic [7:0] out_a;
    logic [3:0] out_b;
    logic       tc_a, tc_b, wrap_a, wrap_b;

    int total = 0;
    int bad   = 0;

    always #5 Clk = ~Clk;

    eight_bit_counter_behaviour dut_a (
        .Clk  (Clk),
        .rst  (rst_a),
        .out  (out_a),
        .tc   (tc_a),
        .wrap (wrap_a)
    );

    eight_bit_counter_behaviour #(
        .WIDTH       (4),
        .RESET_VALUE (4'd2),
        .STEP        (3)
    ) dut_b (
        .Clk  (Clk),
        .rst  (rst_b),
        .out  (out_b),
        .tc   (tc_b),
        .wrap (wrap_b)
    );

    typedef struct {
        logic       rst;
        logic [7:0] out;
        logic       tc;
        logic       wrap;
    } vec_t;

    vec_t va [7];
    vec_t vb [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // one edge on dut_a, then sample 1 time unit later
    task automatic edge_a(input logic r);
        rst_a = r;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_a(input string name, input logic [7:0] eo, input logic etc, input logic ew);
        chk({name, ".out"},  32'(out_a),  32'(eo));
        chk({name, ".tc"},   32'(tc_a),   32'(etc));
        chk({name, ".wrap"}, 32'(wrap_a), 32'(ew));
    endtask

    initial begin
        rst_a = 1'b0;
        rst_b = 1'b0;

        // reset hold, then count 1..5
        va[0] = '{1'b0, 8'h00, 1'b0, 1'b0};
        va[1] = '{1'b0, 8'h00, 1'b0, 1'b0};
        va[2] = '{1'b1, 8'h01, 1'b0, 1'b0};
        va[3] = '{1'b1, 8'h02, 1'b0, 1'b0};
        va[4] = '{1'b1, 8'h03, 1'b0, 1'b0};
        va[5] = '{1'b1, 8'h04, 1'b0, 1'b0};
        va[6] = '{1'b1, 8'h05, 1'b0, 1'b0};

        // WIDTH=4 STEP=3 RESET_VALUE=2: 2 5 8 11 14 1 4
        vb[0] = '{1'b0, 8'd2,  1'b0, 1'b0};
        vb[1] = '{1'b1, 8'd5,  1'b0, 1'b0};
        vb[2] = '{1'b1, 8'd8,  1'b0, 1'b0};
        vb[3] = '{1'b1, 8'd11, 1'b0, 1'b0};
        vb[4] = '{1'b1, 8'd14, 1'b1, 1'b0};
        vb[5] = '{1'b1, 8'd1,  1'b0, 1'b1};
        vb[6] = '{1'b1, 8'd4,  1'b0, 1'b0};

        for (int i = 0; i < 7; i++) begin
            rst_a = va[i].rst;
            rst_b = vb[i].rst;
            @(posedge Clk);
            #1;
            chk($sformatf("a_vec%0d.out", i),  32'(out_a),  32'(va[i].out));
            chk($sformatf("a_vec%0d.tc", i),   32'(tc_a),   32'(va[i].tc));
            chk($sformatf("a_vec%0d.wrap", i), 32'(wrap_a), 32'(va[i].wrap));
            chk($sformatf("b_vec%0d.out", i),  32'(out_b),  32'(vb[i].out[3:0]));
            chk($sformatf("b_vec%0d.tc", i),   32'(tc_b),   32'(vb[i].tc));
            chk($sformatf("b_vec%0d.wrap", i), 32'(wrap_b), 32'(vb[i].wrap));
        end

        // full wrap from 0: 255 edges to FF, then 00 with wrap, then 01
        edge_a(1'b0);
        chk_a("wrap_rst", 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 254; i++) edge_a(1'b1);
        chk_a("pre_ff", 8'hFE, 1'b0, 1'b0);
        edge_a(1'b1);
        chk_a("at_ff", 8'hFF, 1'b1, 1'b0);
        edge_a(1'b1);
        chk_a("wrapped", 8'h00, 1'b0, 1'b1);
        edge_a(1'b1);
        chk_a("post_wrap", 8'h01, 1'b0, 1'b0);

        // reset mid-count at 02
        edge_a(1'b1);
        chk_a("at_02", 8'h02, 1'b0, 1'b0);
        edge_a(1'b0);
        chk_a("mid_rst", 8'h00, 1'b0, 1'b0);
        edge_a(1'b1);
        chk_a("mid_rel", 8'h01, 1'b0, 1'b0);

        // rst pulsed low between edges only: count must continue
        #2 rst_a = 1'b0;
        #2 rst_a = 1'b1;
        @(posedge Clk);
        #1;
        chk_a("glitch", 8'h02, 1'b0, 1'b0);

        // reset while at FF: reset wins over the wrap pulse
        edge_a(1'b0);
        for (int i = 0; i < 255; i++) edge_a(1'b1);
        chk_a("ff_again", 8'hFF, 1'b1, 1'b0);
        edge_a(1'b0);
        chk_a("rst_at_ff", 8'h00, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
